// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: four FU result lanes in, two register-file write ports out,
// plus the branch flush/clear controls that act on buffered results.
interface wb_port_arbiter_if #(
    parameter int PW  = 64,
    parameter int CK  = 4,
    parameter int CKL = 2
);
    logic [3:0]      lane_valid_i;
    logic [4*PW-1:0] lane_payload_i;
    logic [4*CK-1:0] lane_mask_i;
    logic [3:0]      lane_ready_o;
    logic            flush_i;
    logic            clear_i;
    logic [CKL-1:0]  tag_i;
    logic [1:0]      port_valid_o;
    logic [2*PW-1:0] port_payload_o;
    logic [3:0]      port_lane_o;

    modport master (
        output lane_valid_i, lane_payload_i, lane_mask_i, flush_i, clear_i, tag_i,
        input  lane_ready_o, port_valid_o, port_payload_o, port_lane_o
    );

    modport slave (
        input  lane_valid_i, lane_payload_i, lane_mask_i, flush_i, clear_i, tag_i,
        output lane_ready_o, port_valid_o, port_payload_o, port_lane_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Per-lane 2-deep result FIFOs feeding two writeback ports through a round-robin
// grant, with branch-mask based squash (flush) and resolve (clear) of buffered entries.
module wb_port_arbiter #(
    parameter int PW  = 64,
    parameter int CK  = 4,
    parameter int CKL = 2
) (
    input  logic             clk,
    input  logic             reset,
    wb_port_arbiter_if.slave bus
);
    logic [CK-1:0]   tagBit;
    logic [CK-1:0]   clearMask;
    logic [3:0]      laneReady;
    logic [3:0]      headLive;
    logic [3:0]      pop;
    logic [PW-1:0]   headPayload [4];
    logic [1:0]      rrReg, rrNext;
    logic [1:0]      portValidReg;
    logic [2*PW-1:0] portPayloadReg;
    logic [3:0]      portLaneReg;
    logic            g0Valid, g1Valid;
    logic [1:0]      g0Lane, g1Lane, scanLane;

    assign tagBit    = CK'(1) << bus.tag_i;
    // Flush wins over clear when both arrive together.
    assign clearMask = (bus.clear_i && !bus.flush_i) ? tagBit : '0;

    for (genvar gi = 0; gi < 4; gi++) begin : gLane
        logic [1:0]    countReg, countNext;
        logic [PW-1:0] payloadReg [2];
        logic [PW-1:0] payloadNext [2];
        logic [CK-1:0] maskReg [2];
        logic [CK-1:0] maskNext [2];
        logic [PW-1:0] inPayload;
        logic [CK-1:0] inMask;
        logic [1:0]    drop, keep;
        logic          pushStore;

        assign inPayload       = bus.lane_payload_i[gi*PW +: PW];
        assign inMask          = bus.lane_mask_i[gi*CK +: CK];
        assign laneReady[gi]   = (countReg < 2'd2);
        assign drop[0]         = bus.flush_i && (countReg > 2'd0) && ((maskReg[0] & tagBit) != '0);
        assign drop[1]         = bus.flush_i && (countReg > 2'd1) && ((maskReg[1] & tagBit) != '0);
        assign headLive[gi]    = (countReg != 2'd0) && !drop[0];
        assign headPayload[gi] = payloadReg[0];
        assign keep[0]         = headLive[gi] && !pop[gi];
        assign keep[1]         = (countReg > 2'd1) && !drop[1];
        // A squashed incoming result is accepted (ready was high) but never stored.
        assign pushStore = bus.lane_valid_i[gi] && laneReady[gi]
                           && !(bus.flush_i && ((inMask & tagBit) != '0));

        // Slot 0 is always the head: survivors compact toward it, then the push lands behind.
        always_comb begin
            payloadNext[0] = payloadReg[0];
            payloadNext[1] = payloadReg[1];
            maskNext[0]    = maskReg[0] & ~clearMask;
            maskNext[1]    = maskReg[1] & ~clearMask;
            countNext      = 2'd0;
            if (keep[0]) begin
                countNext = 2'd1;
            end
            if (keep[1]) begin
                if (!keep[0]) begin
                    payloadNext[0] = payloadReg[1];
                    maskNext[0]    = maskReg[1] & ~clearMask;
                end
                countNext = countNext + 2'd1;
            end
            if (pushStore) begin
                if (countNext == 2'd0) begin
                    payloadNext[0] = inPayload;
                    maskNext[0]    = inMask & ~clearMask;
                end else begin
                    payloadNext[1] = inPayload;
                    maskNext[1]    = inMask & ~clearMask;
                end
                countNext = countNext + 2'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                countReg <= 2'd0;
            end else begin
                countReg <= countNext;
            end
            payloadReg[0] <= payloadNext[0];
            payloadReg[1] <= payloadNext[1];
            maskReg[0]    <= maskNext[0];
            maskReg[1]    <= maskNext[1];
        end
    end

    // Scan four lanes starting at rr; the first two live heads take ports 0 and 1.
    always_comb begin
        g0Valid  = 1'b0;
        g1Valid  = 1'b0;
        g0Lane   = 2'd0;
        g1Lane   = 2'd0;
        pop      = '0;
        rrNext   = rrReg;
        scanLane = 2'd0;
        for (int i = 0; i < 4; i++) begin
            scanLane = rrReg + 2'(i);
            if (headLive[scanLane] && !g1Valid) begin
                pop[scanLane] = 1'b1;
                rrNext        = scanLane + 2'd1;
                if (!g0Valid) begin
                    g0Valid = 1'b1;
                    g0Lane  = scanLane;
                end else begin
                    g1Valid = 1'b1;
                    g1Lane  = scanLane;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rrReg          <= 2'd0;
            portValidReg   <= 2'b00;
            portPayloadReg <= '0;
            portLaneReg    <= 4'd0;
        end else begin
            rrReg        <= rrNext;
            portValidReg <= {g1Valid, g0Valid};
            if (g0Valid) begin
                portPayloadReg[PW-1:0] <= headPayload[g0Lane];
                portLaneReg[1:0]       <= g0Lane;
            end
            if (g1Valid) begin
                portPayloadReg[2*PW-1:PW] <= headPayload[g1Lane];
                portLaneReg[3:2]          <= g1Lane;
            end
        end
    end

    assign bus.lane_ready_o   = laneReady;
    assign bus.port_valid_o   = portValidReg;
    assign bus.port_payload_o = portPayloadReg;
    assign bus.port_lane_o    = portLaneReg;
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter PW, default 64, meaning width of one writeback payload in bits.
REQ-002 SHALL have parameter CK, default 4, meaning number of branch checkpoints (mask width).
REQ-003 SHALL have parameter CKL, default 2, meaning log2(CK), the width of a checkpoint tag.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port lane_valid_i, input, 4 bits: per-lane result valid (4 FU lanes).
REQ-007 SHALL have port lane_payload_i, input, 4*PW bits: lane k payload at [k*PW+PW-1:k*PW].
REQ-008 SHALL have port lane_mask_i, input, 4*CK bits: lane k branch mask at [k*CK+CK-1:k*CK].
REQ-009 SHALL have port lane_ready_o, output, 4 bits: lane k can accept one entry this cycle.
REQ-010 SHALL have port flush_i, input, 1 bit: mispredict squash request.
REQ-011 SHALL have port clear_i, input, 1 bit: correct-resolve request.
REQ-012 SHALL have port tag_i, input, CKL bits: checkpoint for flush_i or clear_i.
REQ-013 SHALL have port port_valid_o, output, 2 bits: register-file write port p valid.
REQ-014 SHALL have port port_payload_o, output, 2*PW bits: port p payload at [p*PW+PW-1:p*PW].
REQ-015 SHALL have port port_lane_o, output, 4 bits: source lane of port p at [2p+1:2p].

Function
REQ-016 SHALL hold one 2-entry FIFO per lane; each entry stores the payload and the mask.
REQ-017 SHALL drive lane_ready_o[k] = (count_k < 2), from state only, with no dependence on the same-cycle grant.
REQ-018 SHALL write the entry into FIFO k at the edge when lane_valid_i[k] and lane_ready_o[k] are both high.
REQ-019 SHALL, each cycle, grant up to 2 non-empty lanes, scanning in round-robin order from pointer rr (2 bits).
REQ-020 SHALL assign the first granted lane to port 0 and the second to port 1.
REQ-021 SHALL pop each granted FIFO head at the edge.
REQ-022 SHALL register the granted heads into the port outputs at the same edge, so write at edge N gives earliest output in the cycle after edge N+1 (2-cycle latency).
REQ-023 SHALL set rr to (last granted lane + 1) mod 4 after each grant, and leave rr unchanged when nothing is granted.
REQ-024 SHALL drive port_valid_o[p] = 0 when no lane is granted to port p; port_payload_o and port_lane_o are then don't-care but SHALL hold their last values.
REQ-025 SHALL keep each lane in order: within a lane, entries leave in arrival order.
REQ-026 SHALL not grant two ports to one lane in the same cycle.
REQ-027 SHALL, on flush_i, drop at that edge every stored entry whose mask bit [tag_i] is 1.
REQ-028 SHALL, on flush_i, exclude such entries from that cycle's grant, so their port_valid_o is 0 next cycle.
REQ-029 SHALL, on flush_i, complete the handshake for an incoming entry whose mask bit [tag_i] is 1 but not store it.
REQ-030 SHALL, when a flushed head is dropped and the tail survives, make the tail the new head; count equals surviving entries.
REQ-031 SHALL, on clear_i, zero mask bit [tag_i] in all stored entries and in entries written that edge.
REQ-032 SHALL give flush_i priority when flush_i and clear_i are both asserted, with clear_i ignored that cycle.
REQ-033 SHALL compute pop, flush drop and push in one edge: new count = count - popped - dropped + pushed.
REQ-034 SHALL never let count exceed 2 and never let count underflow.

Reset
REQ-035 SHALL, while reset is high at an edge, set all counts to 0, rr to 0, port_valid_o to 0, port_payload_o to 0 and port_lane_o to 0.
REQ-036 SHALL discard all FIFO contents on reset, including mid-operation.
REQ-037 SHALL drive lane_ready_o = 4'b1111 from the first cycle after reset.
REQ-038 SHALL ignore lane_valid_i, flush_i and clear_i during reset.

Verification
REQ-039 SHALL cover single entry: lane 2 valid, payload 0xA5, one cycle after reset -> port_valid_o=01, port_payload_o[0]=0xA5 and port_lane_o[1:0]=2, two edges later; rr=3.
REQ-040 SHALL cover all lanes valid every cycle from reset -> grants (0,1), (2,3), (0,1) and so on, with no lane starved and exactly 2 writes per cycle.
REQ-041 SHALL cover full lane: lane 1 pushes 2 entries with no grants available (lanes 0,2,3 win) -> lane_ready_o[1]=0 until lane 1 pops; then it rises the next cycle.
REQ-042 SHALL cover flush: lane 0 holds masks 0010 and 0000, flush_i with tag_i=1 -> the head is dropped, count=1, and only the 0000 entry is ever output.
REQ-043 SHALL cover clear then flush: clear_i with tag_i=2 on an entry with mask 0100, then flush_i with tag_i=2 -> the entry survives and is output.
REQ-044 SHALL cover reset mid-stream: 6 entries buffered, reset asserted one cycle -> port_valid_o=00 the next cycle, no buffered entry ever appears, lane_ready_o=1111.
